// File: rtl/piero.sv
// piero: dual-channel priority encoder and BCD-to-decimal decoder with registered outputs
module piero (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [1:0] YA,
  output logic       EA,
  output logic [9:0] YB,
  output logic       EB
);
  logic [1:0] ya_d;
  logic       ea_d;
  logic [9:0] yb_d;
  logic       eb_d;
  always_comb begin
    ya_d = A[3] ? 2'd3 : A[2] ? 2'd2 : A[1] ? 2'd1 : 2'd0;
    ea_d = ~|A;
    eb_d = B > 4'd9;
    yb_d = eb_d ? 10'd0 : 10'd1 << B;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      YA <= 2'd0;
      EA <= 1'b0;
      YB <= 10'd0;
      EB <= 1'b0;
    end else begin
      YA <= ya_d;
      EA <= ea_d;
      YB <= yb_d;
      EB <= eb_d;
    end
endmodule

// File: tb/tb_piero.sv
// tb_piero: scoreboard bench for piero; stimulus pushes expectations, monitor pops after each edge
module tb_piero;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] A, B;
  logic [1:0] YA;
  logic       EA;
  logic [9:0] YB;
  logic       EB;

  typedef struct {
    string      nm;
    logic [1:0] ya;
    logic       ea;
    logic [9:0] yb;
    logic       eb;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int errs = 0;

  piero dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .YA(YA), .EA(EA), .YB(YB), .EB(EB));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [1:0] ya, input logic ea,
                       input logic [9:0] yb, input logic eb);
    vectors++;
    if ({YA, EA, YB, EB} !== {ya, ea, yb, eb}) begin
      errs++;
      $display("FAIL %s: got YA=%b EA=%b YB=%b EB=%b, want YA=%b EA=%b YB=%b EB=%b",
               nm, YA, EA, YB, EB, ya, ea, yb, eb);
    end
  endtask

  task automatic apply(input string nm, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] ya, input logic ea, input logic [9:0] yb, input logic eb);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    e.nm = nm; e.ya = ya; e.ea = ea; e.yb = yb; e.eb = eb;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (q.size() != 0) begin
      vectors++;
      errs++;
      $display("FAIL drain: %0d results never appeared, want 0 outstanding", q.size());
      q.delete();
    end
  endtask

  // Monitor: every edge out of reset with an outstanding expectation presents one result.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && q.size() != 0) begin
      e = q.pop_front();
      check(e.nm, e.ya, e.ea, e.yb, e.eb);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    A = 4'd0;
    B = 4'd0;
    #1;
    check("reset_async", 2'd0, 1'b0, 10'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("a0010_b1", 4'b0010, 4'd1, 2'd1, 1'b0, 10'b0000000010, 1'b0);
    apply("a1010_b3", 4'b1010, 4'd3, 2'd3, 1'b0, 10'b0000001000, 1'b0);
    apply("a0000_b8", 4'b0000, 4'd8, 2'd0, 1'b1, 10'b0100000000, 1'b0);
    apply("a1111_b2", 4'b1111, 4'd2, 2'd3, 1'b0, 10'b0000000100, 1'b0);
    apply("a0100_b12", 4'b0100, 4'd12, 2'd2, 1'b0, 10'b0000000000, 1'b1);
    apply("a0001_b9", 4'b0001, 4'd9, 2'd0, 1'b0, 10'b1000000000, 1'b0);
    apply("a0011_b10", 4'b0011, 4'd10, 2'd1, 1'b0, 10'b0000000000, 1'b1);
    for (int b = 0; b < 16; b++)
      apply($sformatf("sweep_b%0d", b), 4'b0100, 4'(b), 2'd2, 1'b0,
            b < 10 ? 10'd1 << b : 10'd0, b >= 10);
    drain();
    apply("pre_reset", 4'b1111, 4'd5, 2'd3, 1'b0, 10'b0000100000, 1'b0);
    drain();
    A = 4'b0001;
    B = 4'd7;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid", 2'd0, 1'b0, 10'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", 2'd0, 1'b0, 10'd0, 1'b0);
    apply("post_reset", 4'b0010, 4'd9, 2'd1, 1'b0, 10'b1000000000, 1'b0);
    rst_n = 1'b1;
    #1;
    check("latency_pre_edge", 2'd0, 1'b0, 10'd0, 1'b0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/piero.md
Name: piero

Overview:
- Dual-channel code converter with registered outputs.
- Channel A: 4-bit input to 2-bit priority encoder, with an "empty" flag.
- Channel B: 4-bit BCD digit to 10-line one-hot decimal decoder, with an "invalid code" flag.
- Used as a small glue/indicator block; both channels are independent and share one clock and reset.

Parameters:
- None. All widths are fixed: A/B 4 bits, YA 2 bits, YB 10 bits.

Ports:
- clk  input  1  system clock; all outputs update on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  4  priority-encoder request vector; bit 3 has the highest priority.
- B  input  4  BCD digit to decode; legal values are 0..9.
- YA  output  2  index of the highest-priority set bit of A.
- EA  output  1  high when A has no bit set.
- YB  output  10  one-hot decimal decode of B; YB[k] high when B==k.
- EB  output  1  high when B is not a legal BCD digit (B>=10).

Behaviour:
- Clock and reset
  - One clock domain; reset is asynchronous and active-low.
  - While rst_n=0, independent of clk: YA=2'b00, EA=0, YB=10'b0, EB=0.
  - After rst_n deasserts, outputs reflect inputs sampled at the next rising clk edge.
- Timing
  - Both channels: combinational logic feeding output registers.
  - Latency is exactly 1 clk cycle from input sample to output.
  - A new result is produced every cycle; there is no handshake.
- Channel A (priority encoder)
  - YA is the index of the highest set bit: A[3]=1 -> 3; else A[2] -> 2; else A[1] -> 1; else A[0] -> 0.
  - EA = 1 iff A == 4'b0000. In that case YA = 2'b00.
  - EA = 0 whenever any bit of A is set.
  - Lower bits are ignored when a higher bit is set.
- Channel B (BCD-to-decimal decoder)
  - For B in 0..9: YB = 1 << B (exactly one bit high) and EB = 0.
  - For B in 10..15: YB = 10'b0 and EB = 1.
- Channel independence
  - The two channels share no logic and have no cross effects.
  - Simultaneous input changes on both channels appear together on the same clock edge.
- Reset mid-operation
  - Asserting rst_n forces the reset values immediately, without waiting for a clock edge.
  - Any pending (sampled but not yet registered) values are discarded.
- X inputs: no defined behaviour is required.

Test Plan:
- Apply reset, then release with A=0010, B=0001 and clock once -> YA=01, EA=0, YB=10'b0000000010, EB=0.
- A=1010, B=0011 -> YA=11, EA=0, YB=10'b0000001000, EB=0. Checks priority masking of A[1].
- A=0000, B=1000 -> YA=00, EA=1, YB=10'b0100000000, EB=0.
- A=1111, B=0010 -> YA=11, EA=0, YB=10'b0000000100, EB=0. Then A=0100, B=1100 -> YA=10, EA=0, YB=0, EB=1.
- A=0100, B=0000 -> YA=10, YB=10'b0000000001, EB=0. Sweep all 16 values of B and check the EB boundary between 9 and 10.
- Assert rst_n low between clock edges while outputs are non-zero -> all outputs go to 0 immediately. Check that the output-change latency is exactly 1 cycle after rst_n releases.
